// File: rtl/borrow_serial_subtractor_pkg.sv
// Shared FSM state encoding and slice constants for the serial borrow subtractor.
package sub_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/borrow_lookahead_2bit.sv
// Combinational 2-bit subtract slice with borrow look-ahead; zero latency, no flow control.
module borrow_lookahead_2bit
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_bin,
  output logic [SLICE_W-1:0] o_d,
  output logic               o_bout
);

  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W-1:0] w_g;
  logic               w_b1;

  // Equal bits pass an incoming borrow through; a=0,b=1 creates one.
  assign w_p = i_a ~^ i_b;
  assign w_g = ~i_a & i_b;

  assign w_b1   = w_g[0] | (w_p[0] & i_bin);
  assign o_bout = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_bin);

  assign o_d[0] = i_a[0] ^ i_b[0] ^ i_bin;
  assign o_d[1] = i_a[1] ^ i_b[1] ^ w_b1;

endmodule

// File: rtl/borrow_serial_subtractor.sv
// Serial a-b-bin, one 2-bit slice per cycle; result valid WIDTH/2 cycles after accept,
// held in DONE until out_ready. SUB_SATURATE_EN clamps d to 0 on borrow-out.
module borrow_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = $clog2(NSLICE + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_d;
  logic               r_borrow;
  logic               r_bout;
  logic [CNT_W-1:0]   r_cnt;

  logic [SLICE_W-1:0] w_slice_d;
  logic               w_slice_bout;
  logic               w_last;
  logic [WIDTH-1:0]   w_d_shift;

  borrow_lookahead_2bit u_slice (
    .i_a    (r_a[SLICE_W-1:0]),
    .i_b    (r_b[SLICE_W-1:0]),
    .i_bin  (r_borrow),
    .o_d    (w_slice_d),
    .o_bout (w_slice_bout)
  );

  assign w_last = (r_cnt == CNT_W'(NSLICE - 1));

  // New slice enters at the top so the LSB slice lands at bit 0 after NSLICE shifts.
  assign w_d_shift = WIDTH'({w_slice_d, r_d} >> SLICE_W);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = BUSY;
      BUSY:    if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_a      <= r_a >> SLICE_W;
          r_b      <= r_b >> SLICE_W;
          r_d      <= w_d_shift;
          r_borrow <= w_slice_bout;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_bout <= w_slice_bout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign bout      = r_bout;

`ifdef SUB_SATURATE_EN
  assign d = r_bout ? '0 : r_d;
`else
  assign d = r_d;
`endif

endmodule

// File: tb/tb_borrow_serial_subtractor.sv
// Directed vector table plus backpressure, reset-abort and random back-to-back sequences.
module tb_borrow_serial_subtractor;

  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH / 2;
  localparam int NVEC  = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic             bout;

  int n_chk  = 0;
  int n_pass = 0;
  int n_hs   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] d_wrap;
    logic             bo;
    int               hold;
  } vec_t;

  vec_t vecs [NVEC];

  borrow_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) n_hs <= n_hs + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [WIDTH-1:0] exp_d(input logic [WIDTH-1:0] dw, input logic bo);
`ifdef SUB_SATURATE_EN
    return bo ? '0 : dw;
`else
    return dw;
`endif
  endfunction

  task automatic do_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic bini,
                       input logic [WIDTH-1:0] dw, input logic bo, input int hold);
    int lat;
    logic [WIDTH-1:0] d_held;
    logic             b_held;
    @(negedge clk);
    a = ai; b = bi; bin = bini; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ai; b = WIDTH'($urandom); bin = ~bini;
    chk("busy_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    chk("d", d, exp_d(dw, bo));
    chk("bout", bout, bo);
    d_held = d;
    b_held = bout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_d", d, d_held);
      chk("hold_bout", bout, b_held);
    end
    if (hold > 0) begin
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("consume_out_valid", out_valid, 0);
    chk("consume_in_ready", in_ready, 1);
    chk("idle_d_retained", d, d_held);
  endtask

  initial begin
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbin;

    vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0};
    vecs[4] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 5};
    vecs[5] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 0};
    vecs[6] = '{8'h01, 8'h01, 1'b1, 8'hFF, 1'b1, 2};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d_wrap, vecs[i].bo, vecs[i].hold);
    end

    // Abort after the second slice: no result may appear.
    @(negedge clk);
    a = 8'h12; b = 8'h34; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_d", d, 0);
    chk("abort_bout", bout, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rbin = 1'($urandom);
      m    = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
      do_op(ra, rb, rbin, m[WIDTH-1:0], m[WIDTH], 0);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("handshake_count", n_hs, NVEC + 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/borrow_serial_subtractor.md
BORROW_SERIAL_SUBTRACTOR -- requirements
Module: borrow_serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be an even number of at least 2.
REQ-002 clk  input  1  rising-edge clock; the only clock of the block.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operand request is valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 d  output  WIDTH  difference.
REQ-012 bout  output  1  borrow-out; 1 when a < b + bin, unsigned.

Function
REQ-013 Result SHALL be d = (a - b - bin) mod 2^WIDTH, with bout as defined in REQ-012.
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 Accept: on a clk edge in IDLE with in_valid=1, the block SHALL latch a, b and bin, clear the slice counter, and enter BUSY.
REQ-016 in_ready SHALL equal 1 only in IDLE; it is a registered state decode, with no combinational path from in_valid.
REQ-017 In BUSY, each edge SHALL resolve one 2-bit slice, LSB slice first.
REQ-018 Slice borrow: p=a^~b and g=~a&b per bit, with 2-bit borrow look-ahead.
REQ-019 The borrow SHALL be carried between slices in a register.
REQ-020 After WIDTH/2 BUSY edges the block SHALL enter DONE and set out_valid=1; latency is WIDTH/2 cycles from the accept edge (4 for WIDTH=8).
REQ-021 In DONE, d, bout and out_valid SHALL hold stable until an edge with out_ready=1, after which the block SHALL return to IDLE with out_valid=0.
REQ-022 A new request SHALL NOT be accepted on the same edge a result is consumed; minimum spacing between accepts is WIDTH/2+2 cycles.
REQ-023 Changes on a, b, bin or in_valid outside the accept edge SHALL have no effect on the result.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 d and bout SHALL retain the last result in IDLE; they are undefined-free but not meaningful in BUSY.

Reset
REQ-026 While rst_n=0: state IDLE, in_ready=1, out_valid=0, d=0, bout=0, counter=0, borrow register=0.
REQ-027 Reset asserted in BUSY or DONE SHALL abort the operation, with no partial result emitted.
REQ-028 After release, the first edge with in_valid=1 SHALL be accepted.

Configuration
REQ-029 With SUB_SATURATE_EN defined, d SHALL be forced to 0 whenever bout=1 (unsigned saturating subtract); bout is unaffected.
REQ-030 Without SUB_SATURATE_EN, d SHALL wrap modulo 2^WIDTH.
REQ-031 Latency and handshake SHALL be identical with and without SUB_SATURATE_EN.

Structure
REQ-032 A shared package sub_pkg SHALL hold the FSM state typedef (IDLE/BUSY/DONE) and the constant SLICE_W=2.
REQ-033 One sub-module, borrow_lookahead_2bit, SHALL be used.
REQ-034 borrow_lookahead_2bit inputs: 2-bit a and b slices plus borrow-in.
REQ-035 borrow_lookahead_2bit outputs: 2-bit difference and borrow-out.
REQ-036 borrow_lookahead_2bit SHALL be purely combinational and instantiated once.

Verification (WIDTH=8)
REQ-037 a=0x5A, b=0x23, bin=0 -> d=0x37, bout=0; out_valid rises exactly 4 edges after accept.
REQ-038 a=0x00, b=0x01, bin=0 -> bout=1; d=0xFF without SUB_SATURATE_EN, d=0x00 with it.
REQ-039 a=0xFF, b=0xFF, bin=1 -> d=0xFF (0x00 with saturation), bout=1.
REQ-040 a=0x80, b=0x7F, bin=1 -> d=0x00, bout=0.
REQ-041 Backpressure: out_ready held 0 for 5 cycles in DONE -> d and bout stable, in_ready=0, and in_valid pulses ignored; out_ready=1 -> IDLE on the next edge.
REQ-042 Reset mid-BUSY after the 2nd slice, then 3 requests back-to-back with random operands and bin against a reference model -> out_valid=0 and in_ready=1 on reset, every result correct, no dropped or duplicated results.
